// File: rtl/alu_seq_pkg.sv
// Shared constants and types for the iterative accumulator sequencer and its ALU.
package alu_seq_pkg;

   localparam int DATA_W = 16;
   localparam int CNT_W  = 4;

   localparam logic [1:0] ALU_ADD   = 2'd0;
   localparam logic [1:0] ALU_SUB   = 2'd1;
   localparam logic [1:0] ALU_NOT_B = 2'd2;
   localparam logic [1:0] ALU_LT    = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } seq_state_t;

endpackage

// File: rtl/alu_accumulator_seq_if.sv
// Command/result handshake bundle between a requester (master) and the sequencer (slave).
interface alu_accumulator_seq_if #(
   parameter int DATA_W = alu_seq_pkg::DATA_W,
   parameter int CNT_W  = alu_seq_pkg::CNT_W
);

   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_load;
   logic [1:0]        cmd_op;
   logic [DATA_W-1:0] cmd_operand;
   logic [CNT_W-1:0]  cmd_repeat;
   logic              res_valid;
   logic              res_ready;
   logic [DATA_W-1:0] res_data;
   logic              busy;

   modport master (
      output cmd_valid, cmd_load, cmd_op, cmd_operand, cmd_repeat, res_ready,
      input  cmd_ready, res_valid, res_data, busy
   );

   modport slave (
      input  cmd_valid, cmd_load, cmd_op, cmd_operand, cmd_repeat, res_ready,
      output cmd_ready, res_valid, res_data, busy
   );

endinterface

// File: rtl/add_sub_logic.sv
// Combinational 16-bit ALU: add, subtract, invert b, unsigned b<a compare.
module add_sub_logic
   import alu_seq_pkg::ALU_ADD, alu_seq_pkg::ALU_SUB, alu_seq_pkg::ALU_NOT_B, alu_seq_pkg::ALU_LT;
(
   input  logic [1:0]                    op,
   input  logic [alu_seq_pkg::DATA_W-1:0] a,
   input  logic [alu_seq_pkg::DATA_W-1:0] b,
   output logic [alu_seq_pkg::DATA_W-1:0] r
);

   localparam int W = alu_seq_pkg::DATA_W;

   // NOTE: default assignment first so no path through the case leaves r unassigned (no latch).
   always_comb begin
      r = '0;
      unique case (op)
         ALU_ADD:   r = a + b;
         ALU_SUB:   r = a - b;
         ALU_NOT_B: r = ~b;
         ALU_LT:    r = {{(W-1){1'b0}}, (b < a)};
         default:   r = '0;
      endcase
   end

endmodule

// File: rtl/alu_accumulator_seq.sv
// Iterative sequencer: applies a latched ALU op to the accumulator a commanded number of
// times, with valid/ready handshakes on both command and result sides.
module alu_accumulator_seq
   import alu_seq_pkg::seq_state_t, alu_seq_pkg::IDLE, alu_seq_pkg::EXEC, alu_seq_pkg::DONE;
#(
   parameter int DATA_W = alu_seq_pkg::DATA_W,
   parameter int CNT_W  = alu_seq_pkg::CNT_W
)(
   input  logic                  clk,
   input  logic                  reset,
   alu_accumulator_seq_if.slave  bus
);

   seq_state_t        r_state;
   seq_state_t        w_next_state;
   logic [DATA_W-1:0] r_acc;
   logic [CNT_W-1:0]  r_cnt;
   logic [1:0]        r_op;
   logic [DATA_W-1:0] r_operand;
   logic [DATA_W-1:0] w_alu_r;
   logic              w_accept;
   logic              w_compute;

   add_sub_logic u_alu (
      .op (r_op),
      .a  (r_acc),
      .b  (r_operand),
      .r  (w_alu_r)
   );

   assign bus.cmd_ready = (r_state == IDLE) && !reset;
   assign bus.res_valid = (r_state == DONE);
   assign bus.res_data  = r_acc;
   assign bus.busy      = (r_state != IDLE);

   assign w_accept  = bus.cmd_valid && bus.cmd_ready;
   assign w_compute = !bus.cmd_load && (bus.cmd_repeat != '0);

   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         IDLE: if (w_accept) w_next_state = w_compute ? EXEC : DONE;
         EXEC: if (r_cnt == CNT_W'(1)) w_next_state = DONE;
         DONE: if (bus.res_ready) w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_op      <= '0;
         r_operand <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_accept) begin
            r_op      <= bus.cmd_op;
            r_operand <= bus.cmd_operand;
            if (bus.cmd_load) r_acc <= bus.cmd_operand;
            else if (w_compute) r_cnt <= bus.cmd_repeat;
         end
         // The ALU only sees latched operands, so the first iteration lands on the edge after accept.
         if (r_state == EXEC) begin
            r_acc <= w_alu_r;
            r_cnt <= r_cnt - CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_alu_accumulator_seq.sv
// Randomized and directed bench for alu_accumulator_seq against an arithmetic reference model.
module tb_alu_accumulator_seq;

   logic clk;
   logic reset;

   alu_accumulator_seq_if bus ();

   alu_accumulator_seq dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int unsigned acc_m    = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int unsigned alu_ref(input int unsigned op, input int unsigned a,
                                           input int unsigned b);
      case (op)
         0:       return (a + b) % 65536;
         1:       return (a + 65536 - b) % 65536;
         2:       return 65535 - b;
         default: return (b < a) ? 1 : 0;
      endcase
   endfunction

   // Issue one command at the current negedge, follow it to completion and release the result.
   task automatic run_cmd(input bit load, input int unsigned op, input int unsigned operand,
                          input int unsigned rep, input int unsigned hold, input bit noise,
                          output int unsigned result);
      int unsigned iters;
      int unsigned lat;
      check("cmd_ready_idle", bus.cmd_ready, 1);
      bus.cmd_valid   = 1'b1;
      bus.cmd_load    = load;
      bus.cmd_op      = op[1:0];
      bus.cmd_operand = operand[15:0];
      bus.cmd_repeat  = rep[3:0];
      @(posedge clk);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      if (load) acc_m = operand;
      iters = load ? 0 : rep;
      lat = 0;
      check("busy_after_accept", bus.busy, 1);
      while (!bus.res_valid && lat < 40) begin
         check("acc_seq", bus.res_data, acc_m);
         @(negedge clk);
         lat++;
         if (lat <= iters) acc_m = alu_ref(op, acc_m, operand);
      end
      check("iterations_to_valid", lat, iters);
      check("result", bus.res_data, acc_m);
      for (int h = 0; h < int'(hold); h++) begin
         bus.res_ready = 1'b0;
         if (noise) begin
            bus.cmd_valid   = 1'b1;
            bus.cmd_load    = 1'($urandom);
            bus.cmd_op      = 2'($urandom);
            bus.cmd_operand = 16'($urandom);
            bus.cmd_repeat  = 4'($urandom);
         end
         @(negedge clk);
         check("hold_valid", bus.res_valid, 1);
         check("hold_data", bus.res_data, acc_m);
         check("hold_busy", bus.busy, 1);
         check("hold_cmd_ready", bus.cmd_ready, 0);
      end
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
      bus.cmd_valid = 1'b0;
      check("idle_valid", bus.res_valid, 0);
      check("idle_busy", bus.busy, 0);
      check("idle_cmd_ready", bus.cmd_ready, 1);
      check("idle_data", bus.res_data, acc_m);
      result = acc_m;
   endtask

   initial begin
      int unsigned res;
      reset           = 1'b1;
      bus.cmd_valid   = 1'b0;
      bus.cmd_load    = 1'b0;
      bus.cmd_op      = 2'd0;
      bus.cmd_operand = 16'd0;
      bus.cmd_repeat  = 4'd0;
      bus.res_ready   = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_cmd_ready", bus.cmd_ready, 0);
      check("rst_res_valid", bus.res_valid, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_acc", bus.res_data, 0);
      reset = 1'b0;
      #1;
      check("post_rst_cmd_ready", bus.cmd_ready, 1);
      @(negedge clk);

      // Directed cases from the plan, with constant expectations alongside the model.
      run_cmd(1, 0, 5, 0, 0, 0, res);       check("load5", res, 5);
      run_cmd(0, 0, 3, 4, 0, 0, res);       check("add3x4", res, 17);
      run_cmd(1, 0, 16'hFFFE, 0, 0, 0, res);
      run_cmd(0, 0, 1, 3, 0, 0, res);       check("add_wrap", res, 16'h0001);
      run_cmd(1, 0, 10, 0, 0, 0, res);
      run_cmd(0, 1, 5, 3, 0, 0, res);       check("sub_wrap", res, 16'hFFFB);
      run_cmd(0, 2, 16'h00FF, 2, 0, 0, res); check("not_b", res, 16'hFF00);
      run_cmd(1, 0, 10, 0, 0, 0, res);
      run_cmd(0, 3, 3, 1, 0, 0, res);       check("lt_true", res, 1);
      run_cmd(1, 0, 3, 0, 0, 0, res);
      run_cmd(0, 3, 10, 1, 0, 0, res);      check("lt_false", res, 0);
      run_cmd(1, 0, 9, 0, 0, 0, res);
      run_cmd(0, 0, 7, 0, 0, 0, res);       check("repeat0", res, 9);
      run_cmd(1, 2, 16'h1234, 15, 0, 0, res); check("load_ignores", res, 16'h1234);
      run_cmd(0, 0, 1, 15, 5, 1, res);      check("backpressure", res, 16'h1243);
      run_cmd(0, 1, 3, 2, 0, 0, res);       check("after_bp", res, 16'h123D);

      // Reset in the middle of a long computation.
      bus.cmd_valid = 1'b1; bus.cmd_load = 1'b0; bus.cmd_op = 2'd0;
      bus.cmd_operand = 16'd1; bus.cmd_repeat = 4'd15;
      @(posedge clk);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("exec_busy", bus.busy, 1);
      reset = 1'b1;
      @(negedge clk);
      acc_m = 0;
      check("midrst_acc", bus.res_data, 0);
      check("midrst_valid", bus.res_valid, 0);
      check("midrst_busy", bus.busy, 0);
      check("midrst_ready_in_rst", bus.cmd_ready, 0);
      reset = 1'b0;
      #1;
      check("midrst_ready", bus.cmd_ready, 1);
      repeat (3) begin
         @(negedge clk);
         check("midrst_no_result", bus.res_valid, 0);
      end

      // Reset and a command together: the command is dropped.
      reset = 1'b1;
      bus.cmd_valid = 1'b1; bus.cmd_load = 1'b1; bus.cmd_operand = 16'hBEEF;
      @(negedge clk);
      reset = 1'b0;
      bus.cmd_valid = 1'b0;
      @(negedge clk);
      check("rst_wins_busy", bus.busy, 0);
      check("rst_wins_acc", bus.res_data, 0);

      for (int i = 0; i < 40; i++) begin
         run_cmd(($urandom_range(3) == 0), $urandom_range(3), $urandom_range(65535),
                 $urandom_range(15), $urandom_range(3), 1'($urandom), res);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
